// File: rtl/multi_read_reg_file.sv
// 1-write / NUM_RD-read register file with per-port collision flags, optional
// write-to-read bypass, read-valid strobes and a sequenced flush sweep.
module multi_read_reg_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 4,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [ADDR_WIDTH-1:0]        wad,
    input  logic                         wen,
    input  logic [NUM_RD-1:0]            ren,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rad,
    output logic [NUM_RD*DATA_WIDTH-1:0] dout,
    output logic [NUM_RD-1:0]            dout_vld,
    output logic [NUM_RD-1:0]            collision,
    input  logic                         flush,
    output logic                         busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t                         state_q;
    logic [ADDR_WIDTH-1:0]          cnt_q;
    logic                           busy_q;
    logic [DEPTH-1:0]               written_q;
    logic [DATA_WIDTH-1:0]          mem_q [DEPTH];
    logic [NUM_RD*DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [NUM_RD-1:0]              vld_q, vld_d;
    logic [NUM_RD-1:0]              coll_q, coll_d;
    logic                           accept;
    logic                           wr_fire;
    logic [ADDR_WIDTH-1:0]          rd_addr;

    // A flush sampled in IDLE takes priority over any write or read that cycle.
    assign accept  = (state_q == IDLE) && !flush;
    assign wr_fire = accept && wen;

    always_comb begin
        dout_d  = dout_q;
        vld_d   = '0;
        coll_d  = '0;
        rd_addr = '0;
        if (accept) begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_addr = rad[i*ADDR_WIDTH +: ADDR_WIDTH];
                if (ren[i]) begin
                    if (wen && (rd_addr == wad)) begin
                        if (BYPASS != 0) begin
                            dout_d[i*DATA_WIDTH +: DATA_WIDTH] = din;
                            vld_d[i] = 1'b1;
                        end else begin
                            coll_d[i] = 1'b1;
                        end
                    end else if (written_q[rd_addr]) begin
                        dout_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr];
                        vld_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            written_q <= '0;
            dout_q    <= '0;
            vld_q     <= '0;
            coll_q    <= '0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= vld_d;
            coll_q <= coll_d;
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_q <= FLUSH;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else if (wen) begin
                        written_q[wad] <= 1'b1;
                    end
                end
                FLUSH: begin
                    written_q[cnt_q] <= 1'b0;
                    cnt_q            <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage carries no reset; the written bitmap masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wad] <= din;
        end else if (state_q == FLUSH) begin
            mem_q[cnt_q] <= '0;
        end
    end

    assign dout      = dout_q;
    assign dout_vld  = vld_q;
    assign collision = coll_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_multi_read_reg_file.sv
// Directed and randomized bench for multi_read_reg_file; a BYPASS=1 and a
// BYPASS=0 instance share stimulus and are checked against an array model.
module tb_multi_read_reg_file;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              resetn;
    logic [DW-1:0]     din;
    logic [AW-1:0]     wad;
    logic              wen;
    logic [NR-1:0]     ren;
    logic [NR*AW-1:0]  rad;
    logic              flush;
    logic [NR*DW-1:0]  dout_a, dout_b;
    logic [NR-1:0]     vld_a, vld_b, coll_a, coll_b;
    logic              busy_a, busy_b;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multi_read_reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1)) u_byp (
        .clk(clk), .resetn(resetn), .din(din), .wad(wad), .wen(wen), .ren(ren), .rad(rad),
        .dout(dout_a), .dout_vld(vld_a), .collision(coll_a), .flush(flush), .busy(busy_a));

    multi_read_reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(0)) u_nobyp (
        .clk(clk), .resetn(resetn), .din(din), .wad(wad), .wen(wen), .ren(ren), .rad(rad),
        .dout(dout_b), .dout_vld(vld_b), .collision(coll_b), .flush(flush), .busy(busy_b));

    // Reference model: b=0 is the bypass instance, b=1 the non-bypass one.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_wr [DEPTH];
    logic [DW-1:0] m_dout [2][NR];
    bit            m_vld [2][NR];
    bit            m_coll [2][NR];
    bit            m_busy;
    int            m_left;
    int            m_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) m_wr[a] = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NR; i++) begin
                m_dout[b][i] = '0;
                m_vld[b][i]  = 0;
                m_coll[b][i] = 0;
            end
        m_busy = 0;
        m_left = 0;
        m_idx  = 0;
    endtask

    task automatic model_edge();
        int ra;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NR; i++) begin
                m_vld[b][i]  = 0;
                m_coll[b][i] = 0;
            end
        if (m_busy) begin
            m_mem[m_idx] = '0;
            m_wr[m_idx]  = 0;
            m_idx++;
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_idx  = 0;
            end
        end else if (flush) begin
            m_busy = 1;
            m_left = DEPTH;
            m_idx  = 0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (!ren[i]) continue;
                ra = int'(rad[i*AW +: AW]);
                if (wen && ra == int'(wad)) begin
                    m_dout[0][i] = din;
                    m_vld[0][i]  = 1;
                    m_coll[1][i] = 1;
                end else if (m_wr[ra]) begin
                    for (int b = 0; b < 2; b++) begin
                        m_dout[b][i] = m_mem[ra];
                        m_vld[b][i]  = 1;
                    end
                end
            end
            if (wen) begin
                m_mem[wad] = din;
                m_wr[wad]  = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("busy byp", 32'(busy_a), 32'(m_busy));
        chk("busy nobyp", 32'(busy_b), 32'(m_busy));
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("dout byp p%0d", i), 32'(dout_a[i*DW +: DW]), 32'(m_dout[0][i]));
            chk($sformatf("dout nobyp p%0d", i), 32'(dout_b[i*DW +: DW]), 32'(m_dout[1][i]));
            chk($sformatf("vld byp p%0d", i), 32'(vld_a[i]), 32'(m_vld[0][i]));
            chk($sformatf("vld nobyp p%0d", i), 32'(vld_b[i]), 32'(m_vld[1][i]));
            chk($sformatf("coll byp p%0d", i), 32'(coll_a[i]), 32'(m_coll[0][i]));
            chk($sformatf("coll nobyp p%0d", i), 32'(coll_b[i]), 32'(m_coll[1][i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (resetn) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        wen = 0; ren = '0; flush = 0; din = '0; wad = '0; rad = '0;
    endtask

    task automatic set_rad(input int port, input int addr);
        rad[port*AW +: AW] = AW'(addr);
    endtask

    initial begin
        int busy_cycles;
        int guard;
        resetn = 0;
        idle_inputs();
        model_reset();

        // Test 1: reset state with all ports enabled.
        ren = '1;
        for (int i = 0; i < NR; i++) set_rad(i, i);
        #1;
        check_all();
        @(negedge clk);
        check_all();
        resetn = 1;
        step();
        chk("t1 vld after reset", 32'(vld_a), 32'h0);

        // Test 2: two ports reading the same written address.
        idle_inputs();
        wen = 1; wad = 3; din = 16'hA5A5;
        step();
        idle_inputs();
        ren = 4'b0101; set_rad(0, 3); set_rad(2, 3);
        step();
        chk("t2 dout0", 32'(dout_a[0 +: DW]), 32'hA5A5);
        chk("t2 dout2", 32'(dout_a[2*DW +: DW]), 32'hA5A5);
        chk("t2 vld", 32'(vld_a), 32'h5);
        chk("t2 coll", 32'(coll_a), 32'h0);

        // Test 3: same-cycle write/read hit on port 1.
        idle_inputs();
        wen = 1; wad = 7; din = 16'h1111;
        step();
        idle_inputs();
        wen = 1; wad = 7; din = 16'h2222; ren = 4'b0010; set_rad(1, 7);
        step();
        chk("t3 byp dout1", 32'(dout_a[DW +: DW]), 32'h2222);
        chk("t3 byp vld1", 32'(vld_a[1]), 32'h1);
        chk("t3 nobyp coll1", 32'(coll_b[1]), 32'h1);
        chk("t3 nobyp vld1", 32'(vld_b[1]), 32'h0);
        idle_inputs();
        ren = 4'b0010; set_rad(1, 7);
        step();
        chk("t3 nobyp mem7", 32'(dout_b[DW +: DW]), 32'h2222);

        // Test 4: read-after-write and read of a never-written entry.
        idle_inputs();
        wen = 1; wad = 5; din = 16'h00FF;
        step();
        idle_inputs();
        ren = 4'b1001; set_rad(0, 5); set_rad(3, 6);
        step();
        chk("t4 dout0", 32'(dout_a[0 +: DW]), 32'h00FF);
        chk("t4 vld3", 32'(vld_a[3]), 32'h0);

        // Test 5: fill everything, flush, writes ignored while busy.
        for (int a = 0; a < DEPTH; a++) begin
            idle_inputs();
            wen = 1; wad = AW'(a); din = DW'($urandom);
            step();
        end
        idle_inputs();
        flush = 1; wen = 1; wad = 9; din = 16'hBEEF;
        step();
        busy_cycles = 0;
        guard = 0;
        while (busy_a && guard < 100) begin
            busy_cycles++;
            guard++;
            idle_inputs();
            wen = 1; wad = AW'($urandom); din = DW'($urandom); ren = '1;
            step();
        end
        chk("t5 busy cycles", 32'(busy_cycles), 32'(DEPTH));
        for (int a = 0; a < DEPTH; a += NR) begin
            idle_inputs();
            ren = '1;
            for (int i = 0; i < NR; i++) set_rad(i, a + i);
            step();
            chk("t5 vld after flush", 32'(vld_a | vld_b), 32'h0);
        end

        // Test 6: reset in the middle of a flush sweep.
        idle_inputs();
        flush = 1;
        step();
        idle_inputs();
        for (int c = 1; c < 10; c++) step();
        resetn = 0;
        #1;
        model_reset();
        chk("t6 busy in reset", 32'(busy_a), 32'h0);
        check_all();
        step();
        resetn = 1;
        step();
        wen = 1; wad = 12; din = 16'h3C3C;
        step();
        idle_inputs();
        ren = 4'b0100; set_rad(2, 12);
        step();
        chk("t6 dout2", 32'(dout_a[2*DW +: DW]), 32'h3C3C);
        chk("t6 vld2", 32'(vld_a[2]), 32'h1);

        // Randomized traffic on a narrow address window to provoke hits.
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 99) == 0);
            wen   = 1'($urandom);
            wad   = AW'($urandom_range(0, 7));
            din   = DW'($urandom);
            ren   = NR'($urandom);
            for (int i = 0; i < NR; i++) set_rad(i, $urandom_range(0, 7));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
